// File: rtl/wb_interconnect_pkg.sv
// rtl/wb_interconnect_pkg.sv - shared types and helpers for the N-slave Wishbone interconnect
package wb_interconnect_pkg;

  localparam int SLAVE_SEL_BITS = 8;
  // Widest master address the index helper accepts.
  localparam int MAX_ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RESP,
    ST_RELEASE
  } wb_state_e;

  function automatic logic [SLAVE_SEL_BITS-1:0] slave_index(
    input logic [MAX_ADDR_WIDTH-1:0] adr,
    input int                        addr_width
  );
    logic [MAX_ADDR_WIDTH-1:0] shifted;
    shifted = adr >> (addr_width - SLAVE_SEL_BITS);
    return shifted[SLAVE_SEL_BITS-1:0];
  endfunction

endpackage

// File: rtl/wb_int_aggregator.sv
// rtl/wb_int_aggregator.sv - masked, registered slave interrupt vector and its OR
module wb_int_aggregator #(
  parameter int                    NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES-1:0] INT_MASK   = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SLAVES-1:0] int_i,
  output logic [NUM_SLAVES-1:0] int_vec_o,
  output logic                  int_o
);

  logic [NUM_SLAVES-1:0] vec_d, vec_q;
  logic                  int_q;

  assign vec_d = int_i & INT_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      int_q <= 1'b0;
    end else begin
      vec_q <= vec_d;
      int_q <= |vec_d;
    end
  end

  assign int_vec_o = vec_q;
  assign int_o     = int_q;

endmodule

// File: rtl/wishbone_interconnect_n.sv
// rtl/wishbone_interconnect_n.sv - N-slave Wishbone classic interconnect, one outstanding transfer
module wishbone_interconnect_n
  import wb_interconnect_pkg::*;
#(
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [NUM_SLAVES-1:0] INT_MASK       = '1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             m_we_i,
  input  logic                             m_cyc_i,
  input  logic                             m_stb_i,
  input  logic [DATA_WIDTH/8-1:0]          m_sel_i,
  input  logic [ADDR_WIDTH-1:0]            m_adr_i,
  input  logic [DATA_WIDTH-1:0]            m_dat_i,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic                             m_int_o,
  output logic [NUM_SLAVES-1:0]            m_int_vec_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH/8-1:0]          s_sel_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]            s_int_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  wb_state_e                 state_q, state_d;
  logic [SLAVE_SEL_BITS-1:0] idx_q, idx_d, req_idx;
  logic                      valid_q, valid_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]     adr_q, adr_d;
  logic [DATA_WIDTH-1:0]     wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0]     rdat_q, rdat_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic                      stb_q, stb_d;

  logic                      ack_sel;
  logic [DATA_WIDTH-1:0]     rdat_mux;
  logic [NUM_SLAVES-1:0]     slave_vec;

  assign req_idx = slave_index(MAX_ADDR_WIDTH'(m_adr_i), ADDR_WIDTH);

  always_comb begin
    ack_sel   = 1'b0;
    rdat_mux  = '0;
    slave_vec = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (int'(idx_q) == k) begin
        ack_sel      = s_ack_i[k];
        rdat_mux     = s_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        slave_vec[k] = 1'b1;
      end
    end
  end

  // An unmapped index still spends one strobe-less ACTIVE cycle, so the error
  // arrives with the same latency as the fastest possible slave ack.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    stb_d   = stb_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          idx_d   = req_idx;
          valid_d = int'(req_idx) < NUM_SLAVES;
          cnt_d   = '0;
          we_d    = m_we_i;
          sel_d   = m_sel_i;
          adr_d   = {{SLAVE_SEL_BITS{1'b0}}, m_adr_i[ADDR_WIDTH-SLAVE_SEL_BITS-1:0]};
          wdat_d  = m_dat_i;
          stb_d   = valid_d;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!m_cyc_i) begin
          stb_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (!valid_q) begin
          err_d   = 1'b1;
          rdat_d  = '0;
          state_d = ST_RESP;
        end else if (ack_sel) begin
          rdat_d  = rdat_mux;
          ack_d   = 1'b1;
          stb_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          rdat_d  = '0;
          stb_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!m_stb_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      stb_q   <= stb_d;
    end
  end

  assign m_dat_o = rdat_q;
  assign m_ack_o = ack_q;
  assign m_err_o = err_q;
  assign s_we_o  = we_q;
  assign s_sel_o = sel_q;
  assign s_adr_o = adr_q;
  assign s_dat_o = wdat_q;
  assign s_stb_o = stb_q ? slave_vec : '0;
  assign s_cyc_o = stb_q ? slave_vec : '0;

  wb_int_aggregator #(
    .NUM_SLAVES(NUM_SLAVES),
    .INT_MASK  (INT_MASK)
  ) u_int_aggregator (
    .clk      (clk),
    .rst      (rst),
    .int_i    (s_int_i),
    .int_vec_o(m_int_vec_o),
    .int_o    (m_int_o)
  );

endmodule

// File: tb/tb_wishbone_interconnect_n.sv
// tb/tb_wishbone_interconnect_n.sv - self-checking bench for wishbone_interconnect_n
module tb_wishbone_interconnect_n;

  localparam int         NS   = 4;
  localparam int         TO   = 8;
  localparam logic [3:0] MASK = 4'b1011;
  localparam logic [127:0] BG = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

  logic         clk = 1'b0;
  logic         rst;
  logic         m_we_i, m_cyc_i, m_stb_i;
  logic [3:0]   m_sel_i;
  logic [31:0]  m_adr_i, m_dat_i, m_dat_o;
  logic         m_ack_o, m_err_o, m_int_o;
  logic [3:0]   m_int_vec_o;
  logic         s_we_o;
  logic [3:0]   s_sel_o;
  logic [31:0]  s_adr_o, s_dat_o;
  logic [3:0]   s_cyc_o, s_stb_o, s_ack_i, s_int_i;
  logic [127:0] s_dat_i;

  wishbone_interconnect_n #(
    .NUM_SLAVES(NS), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TO), .INT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .m_int_o(m_int_o), .m_int_vec_o(m_int_vec_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .s_int_i(s_int_i)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_m_dat = '0, exp_s_adr = '0, exp_s_dat = '0;
  logic        exp_ack = 0, exp_err = 0, exp_s_we = 0, exp_int = 0;
  logic [3:0]  exp_stb = '0, exp_s_sel = '0, exp_int_vec = '0;

  int          cur_t = 0;
  int          ack_cnt, err_cnt, err_t, stb2_cnt;
  logic [3:0]  stb_seen;
  logic [31:0] ack_dat;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({m_dat_o, m_ack_o, m_err_o, m_int_o, m_int_vec_o, s_we_o, s_sel_o,
                 s_adr_o, s_dat_o, s_cyc_o, s_stb_o});
  endfunction

  always @(negedge clk) begin
    chk("m_ack_o", 128'(m_ack_o), 128'(exp_ack));
    chk("m_err_o", 128'(m_err_o), 128'(exp_err));
    chk("m_dat_o", 128'(m_dat_o), 128'(exp_m_dat));
    chk("s_stb_o", 128'(s_stb_o), 128'(exp_stb));
    chk("s_cyc_o", 128'(s_cyc_o), 128'(exp_stb));
    chk("s_adr_o", 128'(s_adr_o), 128'(exp_s_adr));
    chk("s_dat_o", 128'(s_dat_o), 128'(exp_s_dat));
    chk("s_we_o", 128'(s_we_o), 128'(exp_s_we));
    chk("s_sel_o", 128'(s_sel_o), 128'(exp_s_sel));
    chk("m_int_vec_o", 128'(m_int_vec_o), 128'(exp_int_vec));
    chk("m_int_o", 128'(m_int_o), 128'(exp_int));
    if (m_ack_o) begin ack_cnt++; ack_dat = m_dat_o; end
    if (m_err_o) begin err_cnt++; err_t = cur_t; end
    stb_seen = stb_seen | s_stb_o;
    if (s_stb_o[2]) stb2_cnt++;
  end

  // Interrupt model: what was on s_int_i at an edge, masked, shows after that edge.
  task automatic step();
    @(posedge clk);
    exp_int_vec = rst ? 4'b0000 : (s_int_i & MASK);
    exp_int     = |exp_int_vec;
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
    #1;
    chk("async_reset_outputs", all_outs(), 128'h0);
    exp_m_dat = '0; exp_s_adr = '0; exp_s_dat = '0; exp_s_we = 1'b0; exp_s_sel = '0;
    exp_stb = '0; exp_ack = 1'b0; exp_err = 1'b0; exp_int_vec = '0; exp_int = 1'b0;
  endtask

  // Cycle 0 presents the request; a slave ack in cycle a shows as m_ack_o in a+1,
  // an unmapped index errors in cycle 2, a silent slave errors in cycle TO+1.
  task automatic transfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [3:0] sel, input logic [31:0] rdat, input int ack_at,
                          input int abort_at, input int hold, input int rst_at);
    int idx, resp, last_stb, end_t;
    bit mapped, is_ack;
    logic [3:0] onehot;
    logic [127:0] sd;
    idx      = int'(adr[31:24]);
    mapped   = idx < NS;
    onehot   = 4'b0000;
    if (mapped) onehot[idx] = 1'b1;
    is_ack   = mapped && ack_at > 0 && ack_at <= TO;
    resp     = !mapped ? 2 : (is_ack ? ack_at + 1 : TO + 1);
    last_stb = !mapped ? 0 : (abort_at > 0 ? abort_at : resp - 1);
    end_t    = abort_at > 0 ? abort_at + 1 : resp + hold + 2;
    sd = BG;
    if (mapped) sd[idx*32 +: 32] = rdat;
    ack_cnt = 0; err_cnt = 0; err_t = -1; stb2_cnt = 0; stb_seen = '0; ack_dat = '0;

    step(); cur_t = 0;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_sel_i = sel;
    m_adr_i = adr; m_dat_i = wdat; s_dat_i = sd; s_ack_i = '0;
    exp_ack = 1'b0; exp_err = 1'b0; exp_stb = '0;
    for (int t = 1; t <= end_t; t++) begin
      step(); cur_t = t;
      if ((abort_at > 0 && t >= abort_at) || t > resp + hold) begin
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
      end
      s_ack_i = (is_ack && t == ack_at) ? onehot : 4'b0000;
      exp_stb = (t <= last_stb) ? onehot : 4'b0000;
      if (t == 1) begin
        exp_s_we = we; exp_s_sel = sel; exp_s_adr = {8'h00, adr[23:0]}; exp_s_dat = wdat;
      end
      exp_ack = (abort_at == 0) && is_ack && t == resp;
      exp_err = (abort_at == 0) && !is_ack && t == resp;
      if (abort_at == 0 && t == resp) exp_m_dat = is_ack ? rdat : 32'h0;
      if (rst_at > 0 && t == rst_at) begin
        async_reset();
        break;
      end
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
  endtask

  initial begin
    rst = 1'b1;
    m_we_i = 0; m_cyc_i = 0; m_stb_i = 0; m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_ack_i = '0; s_dat_i = BG; s_int_i = '0;
    ack_cnt = 0; err_cnt = 0; err_t = -1; stb2_cnt = 0; stb_seen = '0; ack_dat = '0;
    repeat (3) step();
    chk("reset_outputs", all_outs(), 128'h0);
    rst = 1'b0;
    step();

    transfer(32'h0100_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 3, 0, 0, 0);
    chk("t1_ack_count", 128'(ack_cnt), 128'd1);
    chk("t1_err_count", 128'(err_cnt), 128'd0);
    chk("t1_stb_seen", 128'(stb_seen), 128'(4'b0010));

    transfer(32'h0300_0004, 1'b0, 32'h0, 4'b0011, 32'h0123_4567, 1, 0, 0, 0);
    chk("t2_read_data", 128'(ack_dat), 128'h0123_4567);
    chk("t2_stb_seen", 128'(stb_seen), 128'(4'b1000));
    chk("t2_ack_count", 128'(ack_cnt), 128'd1);

    transfer(32'h0700_0000, 1'b0, 32'h0, 4'hF, 32'h0, 1, 0, 0, 0);
    chk("t3_stb_seen", 128'(stb_seen), 128'h0);
    chk("t3_err_cycle", 128'(err_t), 128'd2);
    chk("t3_ack_count", 128'(ack_cnt), 128'd0);

    transfer(32'hFF00_0000, 1'b1, 32'h5555_AAAA, 4'h1, 32'h0, 0, 0, 0, 0);
    chk("unmapped_ff_err", 128'(err_cnt), 128'd1);

    transfer(32'h0200_0040, 1'b0, 32'h0, 4'hF, 32'h1111_2222, 0, 0, 4, 0);
    chk("t4_stb_cycles", 128'(stb2_cnt), 128'd8);
    chk("t4_err_count", 128'(err_cnt), 128'd1);
    chk("t4_err_cycle", 128'(err_t), 128'd9);

    transfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 32'h7777_8888, 8, 0, 0, 0);
    chk("ack_beats_timeout", 128'(ack_dat), 128'h7777_8888);
    chk("ack_beats_timeout_err", 128'(err_cnt), 128'd0);

    transfer(32'h0000_0020, 1'b1, 32'hABCD_0001, 4'hF, 32'h0, 0, 2, 0, 0);
    chk("t5_abort_no_resp", 128'(ack_cnt + err_cnt), 128'd0);
    transfer(32'h0100_0030, 1'b1, 32'hABCD_0002, 4'hF, 32'h0, 0, 0, 0, 2);
    step(); step();
    rst = 1'b0;
    transfer(32'h0000_0000, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 2, 0, 0, 0);
    chk("t5_after_reset_ack", 128'(ack_cnt), 128'd1);
    chk("t5_after_reset_dat", 128'(ack_dat), 128'hCAFE_F00D);

    s_int_i = 4'b0100;
    step();
    step();
    chk("t6_masked_int", 128'(m_int_o), 128'd0);
    s_int_i = 4'b0001;
    #1;
    chk("t6_vec_latency", 128'(m_int_vec_o), 128'h0);
    step();
    chk("t6_vec", 128'(m_int_vec_o), 128'(4'b0001));
    chk("t6_or", 128'(m_int_o), 128'd1);
    s_int_i = 4'b1111;
    step();
    step();
    chk("t6_all_masked", 128'(m_int_vec_o), 128'(4'b1011));
    s_int_i = 4'b0000;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
